// File: rtl/xaui_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xaui_ctrl_pkg
// Purpose  : Shared constants, state encodings and helpers for xaui_link_ctrl
// Revision : 1.0
// ============================================================================
package xaui_ctrl_pkg;

    localparam int unsigned NUM_LANES     = 4;
    localparam int unsigned CV_WIDTH      = 2 * NUM_LANES;
    localparam int unsigned TIMER_W       = 16;
    localparam int unsigned STABLE_W      = 5;

    localparam int unsigned ALIGN_STABLE  = 4;
    localparam int unsigned CHSYNC_STABLE = 16;

    localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_ONE = STABLE_W'(1);

    localparam logic [2:0] ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_ALIGN      = 3'd2;
    localparam logic [2:0] ST_CHAN_SYNC  = 3'd3;
    localparam logic [2:0] ST_LINK_UP    = 3'd4;
    localparam logic [2:0] ST_BACKOFF    = 3'd5;

    localparam int unsigned STAT_LINK_UP  = 7;
    localparam int unsigned STAT_FAULT    = 6;
    localparam int unsigned STAT_STATE_HI = 5;
    localparam int unsigned STAT_STATE_LO = 3;
    localparam int unsigned STAT_RXLOCK   = 2;
    localparam int unsigned STAT_SYNCOK   = 1;
    localparam int unsigned STAT_ERR_FLAG = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xaui_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : xaui_link_ctrl_if
// Purpose  : MGT quad control/status pins between sequencer and XAUI PHY
// Revision : 1.0
// ============================================================================
interface xaui_link_ctrl_if;
    import xaui_ctrl_pkg::*;

    logic [NUM_LANES-1:0] mgt_rxlock;
    logic [NUM_LANES-1:0] mgt_syncok;
    logic [CV_WIDTH-1:0]  mgt_code_valid;
    logic [NUM_LANES-1:0] mgt_rxbufferr;
    logic [NUM_LANES-1:0] mgt_rx_reset;
    logic [NUM_LANES-1:0] mgt_tx_reset;
    logic [NUM_LANES-1:0] mgt_enable_align;
    logic                 mgt_en_chan_sync;
    logic                 mgt_powerdown;

    // Sequencer side
    modport master (
        input  mgt_rxlock, mgt_syncok, mgt_code_valid, mgt_rxbufferr,
        output mgt_rx_reset, mgt_tx_reset, mgt_enable_align,
               mgt_en_chan_sync, mgt_powerdown
    );

    // PHY side
    modport slave (
        output mgt_rxlock, mgt_syncok, mgt_code_valid, mgt_rxbufferr,
        input  mgt_rx_reset, mgt_tx_reset, mgt_enable_align,
               mgt_en_chan_sync, mgt_powerdown
    );
endinterface
`default_nettype wire

// File: rtl/xaui_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : xaui_err_monitor
// Purpose  : Windowed 8b/10b code-error counter with threshold detect
// Revision : 1.0
// ============================================================================
module xaui_err_monitor
    import xaui_ctrl_pkg::*;
#(
    parameter int unsigned ERR_WINDOW = 1024,
    parameter int unsigned ERR_THRESH = 8
) (
    input  wire logic                mgt_clk,
    input  wire logic                reset_n,
    input  wire logic                enable,
    input  wire logic [CV_WIDTH-1:0] code_valid,
    output logic                     err_hit
);

    localparam logic [TIMER_W-1:0] WIN_LAST    = TIMER_W'(ERR_WINDOW - 1);
    localparam logic [TIMER_W-1:0] THRESH_LAST = TIMER_W'(ERR_THRESH - 1);

    logic [TIMER_W-1:0] win_q, win_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               w_bad;

    assign w_bad = ~&code_valid;

    // Hit fires on the error cycle that brings the count to the threshold.
    assign err_hit = enable && w_bad && (cnt_q == THRESH_LAST);

    always_comb begin
        win_d = '0;
        cnt_d = '0;
        if (enable) begin
            if (win_q != WIN_LAST) begin
                win_d = win_q + TIMER_ONE;
                cnt_d = w_bad ? cnt_q + TIMER_ONE : cnt_q;
            end
        end
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/xaui_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xaui_link_ctrl
// Purpose  : XAUI MGT quad bring-up sequencer with link supervision and retry
// Revision : 1.0
// ============================================================================
module xaui_link_ctrl
    import xaui_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 64,
    parameter int unsigned LOCK_TIMEOUT   = 16'hFFFF,
    parameter int unsigned SYNC_TIMEOUT   = 16'hFFFF,
    parameter int unsigned ERR_WINDOW     = 1024,
    parameter int unsigned ERR_THRESH     = 8,
    parameter int unsigned BACKOFF_CYCLES = 256
) (
    input  wire logic         mgt_clk,
    input  wire logic         reset_n,
    input  wire logic         xaui_reset,
    xaui_link_ctrl_if.master  mgt,
    output logic              link_up,
    output logic [7:0]        retry_count,
    output logic [7:0]        xaui_status
);

    localparam logic [TIMER_W-1:0]  RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  SYNC_LAST    = TIMER_W'(SYNC_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  BACKOFF_LAST = TIMER_W'(BACKOFF_CYCLES - 1);
    localparam logic [STABLE_W-1:0] ALIGN_LAST   = STABLE_W'(ALIGN_STABLE - 1);
    localparam logic [STABLE_W-1:0] CHSYNC_LAST  = STABLE_W'(CHSYNC_STABLE - 1);

    logic [2:0]           state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [STABLE_W-1:0]  stable_q, stable_d;
    logic [7:0]           retry_q, retry_d;
    logic                 fault_q, fault_d;
    logic                 err_flag_q, err_flag_d;
    logic [NUM_LANES-1:0] rx_reset_q, rx_reset_d;
    logic [NUM_LANES-1:0] tx_reset_q, tx_reset_d;
    logic [NUM_LANES-1:0] align_q, align_d;
    logic                 chsync_q, chsync_d;
    logic                 link_up_q, link_up_d;
    logic [7:0]           status_q, status_d;

    logic w_all_lock, w_all_sync, w_buf_err, w_mon_en, w_err_hit;

    assign w_all_lock = &mgt.mgt_rxlock;
    assign w_all_sync = &mgt.mgt_syncok;
    assign w_buf_err  = |mgt.mgt_rxbufferr;
    assign w_mon_en   = (state_q == ST_LINK_UP);

    xaui_err_monitor #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_monitor (
        .mgt_clk    (mgt_clk),
        .reset_n    (reset_n),
        .enable     (w_mon_en),
        .code_valid (mgt.mgt_code_valid),
        .err_hit    (w_err_hit)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TIMER_ONE;
        stable_d   = stable_q;
        retry_d    = retry_q;
        fault_d    = fault_q;
        err_flag_d = err_flag_q;

        if (xaui_reset) begin
            state_d  = ST_RESET_HOLD;
            timer_d  = '0;
            stable_d = '0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (timer_q == RESET_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (timer_q == LOCK_LAST) state_d = ST_BACKOFF;
                    else if (w_all_lock)      state_d = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (timer_q == SYNC_LAST) begin
                        state_d = ST_BACKOFF;
                    end else if (w_all_sync) begin
                        if (stable_q == ALIGN_LAST) state_d = ST_CHAN_SYNC;
                        else                        stable_d = stable_q + STABLE_ONE;
                    end else begin
                        stable_d = '0;
                    end
                end
                ST_CHAN_SYNC: begin
                    if (timer_q == SYNC_LAST) begin
                        state_d = ST_BACKOFF;
                    end else if (w_all_sync && !w_buf_err) begin
                        if (stable_q == CHSYNC_LAST) state_d = ST_LINK_UP;
                        else                         stable_d = stable_q + STABLE_ONE;
                    end else begin
                        stable_d = '0;
                    end
                end
                ST_LINK_UP: begin
                    if (!w_all_lock || !w_all_sync || w_buf_err || w_err_hit)
                        state_d = ST_BACKOFF;
                    if (w_err_hit) err_flag_d = 1'b1;
                end
                ST_BACKOFF: begin
                    if (timer_q == BACKOFF_LAST) state_d = ST_RESET_HOLD;
                end
                default: state_d = ST_RESET_HOLD;
            endcase

            // The sync timeout spans ALIGN and CHAN_SYNC, so that hop keeps the timer.
            if (state_d != state_q) begin
                stable_d = '0;
                if (!(state_q == ST_ALIGN && state_d == ST_CHAN_SYNC)) timer_d = '0;
            end
        end

        if (state_d != state_q) begin
            if (state_d == ST_BACKOFF) begin
                fault_d = 1'b1;
                retry_d = sat_inc8(retry_q);
            end
            if (state_d == ST_LINK_UP)    fault_d    = 1'b0;
            if (state_d == ST_RESET_HOLD) err_flag_d = 1'b0;
        end
    end

    // Pin drive follows the next state so outputs change on the same edge as the state.
    always_comb begin
        rx_reset_d = '0;
        tx_reset_d = '0;
        align_d    = '0;
        chsync_d   = 1'b0;
        link_up_d  = 1'b0;
        case (state_d)
            ST_WAIT_LOCK: rx_reset_d = '1;
            ST_ALIGN:     align_d    = '1;
            ST_CHAN_SYNC: begin
                align_d  = '1;
                chsync_d = 1'b1;
            end
            ST_LINK_UP: begin
                align_d   = '1;
                chsync_d  = 1'b1;
                link_up_d = 1'b1;
            end
            default: begin
                rx_reset_d = '1;
                tx_reset_d = '1;
            end
        endcase

        status_d                              = '0;
        status_d[STAT_LINK_UP]                = link_up_q;
        status_d[STAT_FAULT]                  = fault_q;
        status_d[STAT_STATE_HI:STAT_STATE_LO] = state_q;
        status_d[STAT_RXLOCK]                 = w_all_lock;
        status_d[STAT_SYNCOK]                 = w_all_sync;
        status_d[STAT_ERR_FLAG]               = err_flag_q;
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RESET_HOLD;
            timer_q    <= '0;
            stable_q   <= '0;
            retry_q    <= '0;
            fault_q    <= 1'b0;
            err_flag_q <= 1'b0;
            rx_reset_q <= '1;
            tx_reset_q <= '1;
            align_q    <= '0;
            chsync_q   <= 1'b0;
            link_up_q  <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stable_q   <= stable_d;
            retry_q    <= retry_d;
            fault_q    <= fault_d;
            err_flag_q <= err_flag_d;
            rx_reset_q <= rx_reset_d;
            tx_reset_q <= tx_reset_d;
            align_q    <= align_d;
            chsync_q   <= chsync_d;
            link_up_q  <= link_up_d;
            status_q   <= status_d;
        end
    end

    assign mgt.mgt_rx_reset     = rx_reset_q;
    assign mgt.mgt_tx_reset     = tx_reset_q;
    assign mgt.mgt_enable_align = align_q;
    assign mgt.mgt_en_chan_sync = chsync_q;
    assign mgt.mgt_powerdown    = 1'b0;
    assign link_up              = link_up_q;
    assign retry_count          = retry_q;
    assign xaui_status          = status_q;

endmodule
`default_nettype wire
